dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; a power of two, 2 to 4096.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response valid; 1 to 15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i selects bits [8i+7:8i].
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  initiator takes the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and for errors.
REQ-014 resp_err  output  1  the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have four states: CLEAR, IDLE, WAIT and RESP.
REQ-016 CLEAR SHALL write 0 to one word per cycle, index 0 upward, then go to IDLE after writing index DEPTH_WORDS-1 (DEPTH_WORDS cycles).
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-018 On acceptance, the block SHALL latch req_we, req_addr, req_wdata and req_be; later changes on the request inputs have no effect.
REQ-019 resp_err SHALL be 1 when req_addr[1:0] is not 0, or when req_addr[31:2] is DEPTH_WORDS or more; an error request leaves memory unchanged.
REQ-020 resp_valid SHALL rise exactly LATENCY cycles after the accepting edge, with resp_rdata and resp_err stable from then until the handshake.
REQ-021 A load SHALL return the word at index req_addr[31:2], read at the commit edge; that is the edge that raises resp_valid.
REQ-022 A store SHALL update only the enabled bytes at the commit edge; req_be = 0 is a legal no-op that still gets a response.
REQ-023 In RESP, resp_valid SHALL stay 1 until resp_ready is 1; on that edge the FSM goes to IDLE and resp_valid drops.
REQ-024 A request after a store SHALL see the stored data; there is no read-during-write hazard, because only one request is outstanding at a time.
REQ-025 Back-to-back throughput SHALL be one request per LATENCY+2 cycles when resp_ready is held at 1.
REQ-026 resp_ready when resp_valid is 0 SHALL be ignored; req_valid outside IDLE SHALL be ignored.

Reset
REQ-027 When reset is 0, the block SHALL enter CLEAR with clear index 0 and drive req_ready=0, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-028 Reset asserted mid-operation SHALL abort the transaction: an uncommitted store is never written, and no response is produced.
REQ-029 Reset asserted during CLEAR SHALL restart the sweep from index 0.

Structure
REQ-030 A shared package SHALL hold the state encoding, DEPTH_WORDS and LATENCY defaults, and the byte-lane width constant.
REQ-031 The storage SHALL be one sub-module, dm_ram_be, a synchronous-write, byte-enabled, single-port 32-bit RAM with no reset of its contents.
REQ-032 The latency counter SHALL be 4 bits, loaded on acceptance, and decremented in WAIT; the commit happens when it reaches its terminal value.

Verification
REQ-033 Reset release -> req_ready stays 0 for exactly DEPTH_WORDS cycles, then 1; a load of 0x00000FFC then returns 0x00000000 with resp_err=0.
REQ-034 Store 0x12345678 to 0x10 with be=4'b1111, then store 0xAABBCCDD to 0x10 with be=4'b0101, then load 0x10 -> 0x12BB56DD; each resp_valid appears LATENCY cycles after acceptance.
REQ-035 Load 0x00000002 and load 0x00001000 (DEPTH_WORDS=1024) -> resp_err=1 and resp_rdata=0; a store to 0x1000 leaves every word unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_rdata stay stable, req_ready stays 0, and a concurrent req_valid is not accepted.
REQ-037 Drop reset in WAIT of a store of 0xDEADBEEF to 0x20 -> after the new CLEAR, a load of 0x20 returns 0; drop reset mid-CLEAR -> the sweep restarts and takes a full DEPTH_WORDS cycles.
REQ-038 With LATENCY=1 and resp_ready tied to 1, 8 back-to-back loads -> one acceptance every 3 cycles, responses in order, and no lost or duplicated responses.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the dm_responder memory responder and its byte-enabled RAM.
package dm_responder_pkg;

    localparam int unsigned DEPTH_WORDS_DEF = 32'd1024;
    localparam int unsigned LATENCY_DEF     = 32'd2;
    localparam int unsigned BYTE_W          = 32'd8;
    localparam int unsigned NUM_LANES       = 32'd4;
    localparam int unsigned CNT_W           = 32'd4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_e;

    // A request is rejected when it is not word aligned or its word index is beyond the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/dm_ram_be.sv
// Single-port 32-bit word RAM with per-byte write enables.
// Writes land on the rising edge; reads are combinational; contents are never reset.
module dm_ram_be
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [NUM_LANES-1:0]        be_i,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [NUM_LANES*BYTE_W-1:0] wdata_i,
    output logic [NUM_LANES*BYTE_W-1:0] rdata_o
);

    logic [NUM_LANES*BYTE_W-1:0] mem_q [DEPTH_WORDS];

    // Byte-lane write of the addressed word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding memory responder: zero-fills its RAM after reset, then serves
// one load or store at a time with a fixed response latency of LATENCY cycles.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned LATENCY     = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned       AW       = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0]     LAST_IDX = AW'(DEPTH_WORDS - 32'd1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 32'd1);

    dm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic             lat_we_q, lat_we_d;
    logic [31:0]      lat_addr_q, lat_addr_d;
    logic [31:0]      lat_wdata_q, lat_wdata_d;
    logic [3:0]       lat_be_q, lat_be_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic             ram_we_s;
    logic [3:0]       ram_be_s;
    logic [AW-1:0]    ram_addr_s;
    logic [31:0]      ram_wdata_s;
    logic [31:0]      ram_rdata_s;
    logic             err_s;
    logic [AW-1:0]    lat_idx_s;

    assign err_s     = addr_err(lat_addr_q, DEPTH_WORDS);
    assign lat_idx_s = lat_addr_q[AW+1:2];

    dm_ram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .be_i    (ram_be_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Next-state, RAM port steering and response formation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clr_idx_d    = clr_idx_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        lat_be_d     = lat_be_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ram_we_s     = 1'b0;
        ram_be_s     = 4'b0000;
        ram_addr_s   = lat_idx_s;
        ram_wdata_s  = lat_wdata_q;

        case (state_q)
            ST_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_be_s    = 4'b1111;
                ram_addr_s  = clr_idx_q;
                ram_wdata_s = 32'h0000_0000;
                if (clr_idx_q == LAST_IDX) begin
                    clr_idx_d = {AW{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + AW'(32'd1);
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    lat_we_d    = req_we;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    lat_be_d    = req_be;
                    cnt_d       = CNT_LOAD;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Commit edge: the store lands and the load data is captured together.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    ram_we_s     = lat_we_q & ~err_s;
                    ram_be_s     = lat_be_q;
                    resp_err_d   = err_s;
                    resp_rdata_d = (lat_we_q | err_s) ? 32'h0000_0000 : ram_rdata_s;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(32'd1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_rdata_d = 32'h0000_0000;
                    resp_err_d   = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                clr_idx_d = {AW{1'b0}};
                state_d   = ST_CLEAR;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; reset abandons any request still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= {CNT_W{1'b0}};
            clr_idx_q    <= {AW{1'b0}};
            lat_we_q     <= 1'b0;
            lat_addr_q   <= 32'h0000_0000;
            lat_wdata_q  <= 32'h0000_0000;
            lat_be_q     <= 4'b0000;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clr_idx_q    <= clr_idx_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            lat_be_q     <= lat_be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: a default instance (1024 words, latency 2) under
// random traffic and a small latency-1 instance exercised back-to-back.
`timescale 1ns/1ps
module tb_dm_responder;

    localparam int unsigned DEPTH_A = 1024;
    localparam int unsigned LAT_A   = 2;
    localparam int unsigned DEPTH_B = 16;
    localparam int unsigned LAT_B   = 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_a, req_ready_a, req_we_a;
    logic [31:0] req_addr_a, req_wdata_a;
    logic [3:0]  req_be_a;
    logic        resp_valid_a, resp_ready_a, resp_err_a;
    logic [31:0] resp_rdata_a;
    logic        req_valid_b, req_ready_b, req_we_b;
    logic [31:0] req_addr_b, req_wdata_b;
    logic [3:0]  req_be_b;
    logic        resp_valid_b, resp_err_b;
    logic [31:0] resp_rdata_b;

    int   checks    = 0;
    int   errors    = 0;
    int   cycle_cnt = 0;
    int   rr_mode   = 0;
    bit   stuck     = 1'b0;
    exp_t exp_a_q[$];
    exp_t exp_b_q[$];
    int   acc_a_q[$];
    int   acc_b_q[$];
    logic [31:0] mem_a [DEPTH_A];
    logic [31:0] mem_b [DEPTH_B];

    dm_responder #(.DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_be(req_be_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    dm_responder #(.DEPTH_WORDS(DEPTH_B), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
        .resp_valid(resp_valid_b), .resp_ready(1'b1),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference behaviour: word-addressed array, misaligned or beyond-depth addresses are errors.
    function automatic logic model_err(input logic [31:0] a, input int unsigned depth);
        return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= depth);
    endfunction

    task automatic model_step(input bit is_b, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be, output exp_t e);
        int          idx;
        logic [31:0] word;
        e.err   = model_err(a, is_b ? DEPTH_B : DEPTH_A);
        e.rdata = 32'd0;
        if (!e.err) begin
            idx = int'(a / 32'd4);
            if (is_b) word = mem_b[idx];
            else      word = mem_a[idx];
            if (we) begin
                for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
                if (is_b) mem_b[idx] = word;
                else      mem_a[idx] = word;
            end else begin
                e.rdata = word;
            end
        end
    endtask

    task automatic issue_a(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        int   w = 0;
        exp_t e;
        if (stuck) return;
        @(negedge clk);
        req_valid_a = 1'b1; req_we_a = we; req_addr_a = a; req_wdata_a = wd; req_be_a = be;
        while (!req_ready_a && w < 200) begin @(negedge clk); w++; end
        if (!req_ready_a) begin
            fail("a_accept_timeout");
            stuck = 1'b1;
            req_valid_a = 1'b0;
            return;
        end
        acc_a_q.push_back(cycle_cnt + 1);
        model_step(1'b0, we, a, wd, be, e);
        exp_a_q.push_back(e);
        @(negedge clk);
        req_valid_a = 1'b0;
        req_we_a    = 1'($urandom);
        req_addr_a  = $urandom;
        req_wdata_a = $urandom;
        req_be_a    = 4'($urandom);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        reset = 1'b0;
        exp_a_q.delete(); acc_a_q.delete(); exp_b_q.delete(); acc_b_q.delete();
        for (int i = 0; i < int'(DEPTH_A); i++) mem_a[i] = 32'd0;
        for (int i = 0; i < int'(DEPTH_B); i++) mem_b[i] = 32'd0;
        repeat (hold) @(negedge clk);
        check("rst_req_ready",  32'(req_ready_a),  32'd0);
        check("rst_resp_valid", 32'(resp_valid_a), 32'd0);
        check("rst_resp_rdata", resp_rdata_a,      32'd0);
        check("rst_resp_err",   32'(resp_err_a),   32'd0);
        reset = 1'b1;
    endtask

    task automatic measure_clear(input string name);
        int n = 0;
        while (!req_ready_a && n < 3000) begin @(negedge clk); n++; end
        check(name, 32'(n), 32'(DEPTH_A));
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && w < 1000) begin
            @(negedge clk); w++;
        end
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            fail("drain_timeout");
            stuck = 1'b1;
        end
    endtask

    task automatic run_b();
        exp_t        e;
        int          prev_acc = 0;
        int          acc;
        int          w;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            we = (k < 8);
            a  = 32'((k % 8) * 8);
            wd = $urandom;
            req_valid_b = 1'b1; req_we_b = we; req_addr_b = a; req_wdata_b = wd; req_be_b = 4'hF;
            w = 0;
            while (!req_ready_b && w < 20) begin @(negedge clk); w++; end
            if (!req_ready_b) begin
                fail("b_accept_timeout");
                break;
            end
            acc = cycle_cnt + 1;
            if (k > 0) check("b_accept_spacing", 32'(acc - prev_acc), 32'(LAT_B + 2));
            prev_acc = acc;
            acc_b_q.push_back(acc);
            model_step(1'b1, we, a, wd, 4'hF, e);
            exp_b_q.push_back(e);
            @(negedge clk);
        end
        req_valid_b = 1'b0;
    endtask

    // resp_ready policy for the default instance.
    initial begin
        resp_ready_a = 1'b1;
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       resp_ready_a = 1'b1;
                1:       resp_ready_a = ($urandom_range(0, 3) != 0);
                default: resp_ready_a = 1'b0;
            endcase
        end
    end

    // Monitor for the default instance.
    initial begin : mon_a
        logic        prev_v, prev_r, prev_e;
        logic [31:0] prev_d;
        exp_t        e;
        int          acc;
        prev_v = 1'b0; prev_r = 1'b0; prev_e = 1'b0; prev_d = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid_a) begin
                check("a_req_ready_in_resp", 32'(req_ready_a), 32'd0);
                if (!prev_v) begin
                    if (acc_a_q.size() == 0) fail("a_unexpected_valid");
                    else begin
                        acc = acc_a_q.pop_front();
                        check("a_latency", 32'(cycle_cnt - acc), 32'(LAT_A));
                    end
                end else if (prev_r) begin
                    fail("a_valid_not_dropped");
                end else begin
                    check("a_hold_rdata", resp_rdata_a, prev_d);
                    check("a_hold_err", 32'(resp_err_a), 32'(prev_e));
                end
                if (resp_ready_a) begin
                    if (exp_a_q.size() == 0) fail("a_spurious_response");
                    else begin
                        e = exp_a_q.pop_front();
                        check("a_rdata", resp_rdata_a, e.rdata);
                        check("a_err", 32'(resp_err_a), 32'(e.err));
                    end
                end
            end
            prev_v = resp_valid_a; prev_r = resp_ready_a;
            prev_d = resp_rdata_a; prev_e = resp_err_a;
        end
    end

    // Monitor for the latency-1 instance (resp_ready tied high).
    initial begin : mon_b
        logic prev_v;
        exp_t e;
        int   acc;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid_b) begin
                if (prev_v) fail("b_duplicate_valid");
                if (acc_b_q.size() == 0 || exp_b_q.size() == 0) fail("b_spurious_response");
                else begin
                    acc = acc_b_q.pop_front();
                    e   = exp_b_q.pop_front();
                    check("b_latency", 32'(cycle_cnt - acc), 32'(LAT_B));
                    check("b_rdata", resp_rdata_b, e.rdata);
                    check("b_err", 32'(resp_err_b), 32'(e.err));
                end
            end
            prev_v = resp_valid_b;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          sel;
        reset = 1'b0;
        req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = 32'd0; req_wdata_a = 32'd0; req_be_a = 4'h0;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = 32'd0; req_wdata_b = 32'd0; req_be_b = 4'h0;

        do_reset(3);
        measure_clear("clear_cycles_first");
        issue_a(1'b0, 32'h0000_0FFC, 32'd0, 4'h0);

        issue_a(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111);
        issue_a(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
        issue_a(1'b0, 32'h0000_0010, 32'd0, 4'h0);
        issue_a(1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'b0000);
        issue_a(1'b0, 32'h0000_0014, 32'd0, 4'h0);

        issue_a(1'b0, 32'h0000_0002, 32'd0, 4'h0);
        issue_a(1'b0, 32'h0000_1000, 32'd0, 4'h0);
        issue_a(1'b1, 32'h0000_1000, 32'h5A5A_5A5A, 4'hF);
        issue_a(1'b1, 32'h0000_0013, 32'h5A5A_5A5A, 4'hF);
        drain();

        rr_mode = 2;
        issue_a(1'b0, 32'h0000_0010, 32'd0, 4'h0);
        begin
            int w = 0;
            while (!resp_valid_a && w < 50) begin @(negedge clk); w++; end
            if (!resp_valid_a) fail("hold_wait_valid");
        end
        repeat (5) begin
            req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 32'h0000_0040;
            req_wdata_a = 32'hFFFF_FFFF; req_be_a = 4'hF;
            @(negedge clk);
            check("hold_req_ready", 32'(req_ready_a), 32'd0);
            check("hold_resp_valid", 32'(resp_valid_a), 32'd1);
        end
        req_valid_a = 1'b0;
        rr_mode = 1;
        drain();

        run_b();
        drain();

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
                1:       a = 32'h0000_1000 + 32'($urandom_range(0, 1023)) * 32'd4;
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, 63)) * 32'd4;
            endcase
            issue_a(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        rr_mode = 0;
        for (int i = 0; i < int'(DEPTH_A); i++) issue_a(1'b0, 32'(i) * 32'd4, $urandom, 4'hF);
        drain();

        issue_a(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
        check("abort_in_wait", 32'(resp_valid_a | req_ready_a), 32'd0);
        do_reset(2);
        measure_clear("clear_cycles_after_abort");
        issue_a(1'b0, 32'h0000_0020, 32'd0, 4'h0);
        drain();

        repeat (100) @(negedge clk);
        do_reset(2);
        measure_clear("clear_cycles_restart");
        issue_a(1'b0, 32'h0000_0020, 32'd0, 4'h0);
        issue_a(1'b0, 32'h0000_0FFC, 32'd0, 4'h0);
        drain();
        repeat (5) @(negedge clk);
        check("final_a_queue_empty", 32'(exp_a_q.size()), 32'd0);
        check("final_b_queue_empty", 32'(exp_b_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
